alu_wb_buffer: RTL and testbench
================================

# alu_wb_buffer

Result-capture stage directly downstream of the integer ALU. Takes the ALU's combinational result and overflow bit plus the destination register index, and queues them in a small FIFO. Pops entries to the register-file write port through a valid/ready handshake. Flags ADD/SUB overflow: the overflowing result is never written back, and a sticky status flag and a saturating event counter are updated.

## Interface
Parameters:
- DEPTH, 2: FIFO entries; power of two, 2..16.
- CNT_W, 8: width of overflow event counter.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- alu_out  in  32  ALU result bus.
- alu_ovf  in  1  ALU overflow/borrow bit.
- in_op  in  4  ALU opcode that produced alu_out.
- in_rd  in  5  destination register index.
- in_valid  in  1  producer has a result this cycle.
- in_ready  out  1  buffer can accept (not full).
- wb_valid  out  1  head entry present.
- wb_ready  in  1  register file consumes head.
- wb_data  out  32  head result.
- wb_rd  out  5  head destination index.
- wb_we  out  1  head write enable (qualified by wb_valid).
- ovf_sticky  out  1  set on any trapped overflow.
- ovf_cnt  out  CNT_W  count of trapped overflows, saturating.
- ovf_clr  in  1  synchronous clear of ovf_sticky and ovf_cnt.

## Operation
- Push when in_valid && in_ready. Pop when wb_valid && wb_ready. Push and pop in the same cycle are both honoured; occupancy is unchanged.
- in_ready = (occupancy < DEPTH), registered-state only; it does not depend on wb_ready. When full, a simultaneous pop does not enable a push.
- Trap condition at push: alu_ovf && (in_op == 4'b0100 || in_op == 4'b0101). alu_ovf is ignored for all other opcodes.
- Stored per entry: data, rd, we. we = !trap && (in_rd != 0). A trapped entry still occupies a slot and is still popped, with wb_we=0. wb_data holds the raw alu_out.
- On a trapped push: ovf_sticky <= 1; ovf_cnt increments and holds at all-ones.
- ovf_clr has priority over a same-cycle trap: both registers clear, and that trap is not counted.
- Read/write pointers are log2(DEPTH)+1 bits and wrap modulo 2·DEPTH. Full means the MSBs differ and the rest are equal.
- When wb_valid=0, wb_data, wb_rd and wb_we are 0.

## Timing
- Reset (async assert, sync release): pointers 0, in_ready=1, wb_valid=0, wb_data=0, wb_rd=0, wb_we=0, ovf_sticky=0, ovf_cnt=0.
- Latency without bypass: an entry pushed at edge N is visible on the wb outputs after edge N, and can be popped at edge N+1.
- Throughput: one entry per cycle sustained when wb_ready=1 continuously.
- Entry order is strictly FIFO. No entry is dropped or duplicated under any valid/ready pattern.
- Reset mid-operation flushes all entries. The counter and sticky flag also clear.

## Configuration
- ALU_WB_BYPASS_EN defined: when the FIFO is empty and in_valid=1, the wb outputs show the incoming result combinationally. This includes trap and r0 qualification.
  - If wb_ready=1 in that cycle, the result is consumed without being stored. Pointers are unchanged, but overflow status still updates.
  - If wb_ready=0, the entry is pushed normally.
  - Latency is 0 cycles.
- Not defined: all results pass through storage, with 1-cycle latency as in Timing.

## Test plan
- Reset then push op=0100, alu_out=0x0000_0005, rd=3, ovf=0 with wb_ready=1 -> next cycle wb_valid=1, wb_data=0x5, wb_rd=3, wb_we=1; ovf_cnt=0.
- Push op=0101, alu_out=0xFFFF_FFFF, ovf=1, rd=7 -> popped with wb_we=0; ovf_sticky=1, ovf_cnt=1. Then push op=0000 with ovf=1 -> wb_we=1, ovf_cnt stays 1.
- Push rd=0 with op=0001, data 0xA5A5_A5A5 -> wb_we=0, no overflow update.
- wb_ready=0, push DEPTH entries with values 1..DEPTH -> in_ready=0 after the DEPTH-th push. The next in_valid is ignored. Then wb_ready=1 -> values pop in order 1..DEPTH, in_ready returns to 1 after the first pop.
- Random in_valid/wb_ready for 10k cycles against a scoreboard -> order preserved, no loss, pointer wrap exercised.
- Drive 300 trapped pushes with CNT_W=8 -> ovf_cnt=255. ovf_clr in the same cycle as a trap -> ovf_cnt=0, ovf_sticky=0. Assert rst_n low with 2 entries held -> wb_valid=0 immediately.

Source files
------------

// File: rtl/alu_wb_buffer.sv
// Result-capture FIFO between the integer ALU and the register-file write port, with ADD/SUB overflow trapping.
// Optional build macro ALU_WB_BYPASS_EN: the wb port sees an incoming result in the same cycle when the FIFO is empty.
module alu_wb_buffer #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      alu_out,
  input  logic             alu_ovf,
  input  logic [3:0]       in_op,
  input  logic [4:0]       in_rd,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [31:0]      wb_data,
  output logic [4:0]       wb_rd,
  output logic             wb_we,
  output logic             ovf_sticky,
  output logic [CNT_W-1:0] ovf_cnt,
  input  logic             ovf_clr
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]     wr_ptr, rd_ptr;
  logic [31:0]     mem_data [DEPTH];
  logic [4:0]      mem_rd   [DEPTH];
  logic [DEPTH-1:0] mem_we;

  logic empty, full, trap, in_we, accept, push, pop, bypass_take;

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_ready = !full;

  // Only ADD (0100) and SUB (0101) can trap; alu_ovf is meaningless for other ops.
  assign trap   = alu_ovf && (in_op == 4'b0100 || in_op == 4'b0101);
  assign in_we  = !trap && (in_rd != 5'd0);
  assign accept = in_valid && in_ready;

`ifdef ALU_WB_BYPASS_EN
  assign bypass_take = empty && in_valid && wb_ready;
`else
  assign bypass_take = 1'b0;
`endif

  assign push = accept && !bypass_take;
  assign pop  = !empty && wb_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage carries no reset; outputs are masked while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr[AW-1:0]] <= alu_out;
      mem_rd[wr_ptr[AW-1:0]]   <= in_rd;
      mem_we[wr_ptr[AW-1:0]]   <= in_we;
    end
  end

  always_comb begin
    wb_valid = !empty;
    wb_data  = '0;
    wb_rd    = '0;
    wb_we    = 1'b0;
    if (!empty) begin
      wb_data = mem_data[rd_ptr[AW-1:0]];
      wb_rd   = mem_rd[rd_ptr[AW-1:0]];
      wb_we   = mem_we[rd_ptr[AW-1:0]];
    end
`ifdef ALU_WB_BYPASS_EN
    if (empty && in_valid) begin
      wb_valid = 1'b1;
      wb_data  = alu_out;
      wb_rd    = in_rd;
      wb_we    = in_we;
    end
`endif
  end

  // Clear wins over a same-cycle trap, which is then not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_sticky <= 1'b0;
      ovf_cnt    <= '0;
    end else if (ovf_clr) begin
      ovf_sticky <= 1'b0;
      ovf_cnt    <= '0;
    end else if (accept && trap) begin
      ovf_sticky <= 1'b1;
      if (ovf_cnt != {CNT_W{1'b1}}) ovf_cnt <= ovf_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_wb_buffer.sv
// Scoreboard bench for alu_wb_buffer: driver queues expected entries, negedge monitor pops and compares.
module tb_alu_wb_buffer;
  localparam int DEPTH = 2;
  localparam int CNT_W = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [31:0]      alu_out = '0;
  logic             alu_ovf = 1'b0;
  logic [3:0]       in_op = '0;
  logic [4:0]       in_rd = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             wb_valid;
  logic             wb_ready = 1'b0;
  logic [31:0]      wb_data;
  logic [4:0]       wb_rd;
  logic             wb_we;
  logic             ovf_sticky;
  logic [CNT_W-1:0] ovf_cnt;
  logic             ovf_clr = 1'b0;

  alu_wb_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .alu_out(alu_out), .alu_ovf(alu_ovf), .in_op(in_op),
    .in_rd(in_rd), .in_valid(in_valid), .in_ready(in_ready), .wb_valid(wb_valid),
    .wb_ready(wb_ready), .wb_data(wb_data), .wb_rd(wb_rd), .wb_we(wb_we),
    .ovf_sticky(ovf_sticky), .ovf_cnt(ovf_cnt), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
  } ent_t;

  ent_t q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  bit   m_sticky = 0;
  int   m_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // One cycle of stimulus; expected entries and overflow status come from the rules, not the DUT.
  task automatic step(input logic v, input logic [3:0] op, input logic [31:0] d, input logic ovf,
                      input logic [4:0] rd, input logic wr, input logic clr);
    bit t;
    @(posedge clk); #1;
    chk("in_ready", in_ready, (q.size() < DEPTH));
    chk("ovf_sticky", ovf_sticky, m_sticky);
    chk("ovf_cnt", ovf_cnt, m_cnt);
    in_valid = v; in_op = op; alu_out = d; alu_ovf = ovf; in_rd = rd; wb_ready = wr; ovf_clr = clr;
    t = ovf && (op == 4'd4 || op == 4'd5);
    if (v && q.size() < DEPTH) begin
      q.push_back('{data: d, rd: rd, we: (!t && rd != 5'd0)});
      if (t && !clr) begin
        m_sticky = 1;
        if (m_cnt < CNT_MAX) m_cnt++;
      end
    end
    if (clr) begin
      m_sticky = 0;
      m_cnt = 0;
    end
  endtask

  always @(negedge clk) begin
    ent_t e;
    if (wb_valid && wb_ready) begin
      if (q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_pop: got data %0h with nothing expected", wb_data);
      end else begin
        e = q.pop_front();
        chk("wb_data", wb_data, e.data);
        chk("wb_rd", wb_rd, e.rd);
        chk("wb_we", wb_we, e.we);
      end
    end else if (!wb_valid) begin
      chk("idle_data", wb_data, 32'd0);
      chk("idle_rd_we", {wb_rd, wb_we}, 32'd0);
    end
  end

  initial begin
    logic [3:0] rop;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    chk("rst_in_ready", in_ready, 32'd1);
    chk("rst_wb_valid", wb_valid, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_ovf", {ovf_sticky, ovf_cnt}, 32'd0);

    // basic writeback, then latency check right after the accepting edge
    step(1, 4'b0100, 32'h5, 0, 5'd3, 1, 0);
    step(0, 4'b0000, 32'h0, 0, 5'd0, 1, 0);
    chk("lat_valid", wb_valid, 32'd1);
    chk("lat_data", wb_data, 32'h5);
    step(1, 4'b0101, 32'hFFFF_FFFF, 1, 5'd7, 1, 0);
    step(1, 4'b0000, 32'h1234, 1, 5'd9, 1, 0);
    step(1, 4'b0001, 32'hA5A5_A5A5, 0, 5'd0, 1, 0);
    step(0, 4'b0000, 32'h0, 0, 5'd0, 1, 0);
    step(0, 4'b0000, 32'h0, 0, 5'd0, 1, 0);
    chk("ovf_cnt_after_sub", ovf_cnt, 32'd1);

    // fill with wb_ready low, attempt one more, then drain in order
    for (int i = 1; i <= DEPTH; i++) step(1, 4'b0010, i, 0, 5'd1, 0, 0);
    step(1, 4'b0010, 32'hDEAD, 0, 5'd1, 0, 0);
    chk("full_in_ready", in_ready, 32'd0);
    step(0, 4'b0000, 32'h0, 0, 5'd0, 1, 0);
    step(0, 4'b0000, 32'h0, 0, 5'd0, 1, 0);
    chk("after_pop_ready", in_ready, 32'd1);
    for (int i = 0; i < DEPTH; i++) step(0, 4'b0000, 32'h0, 0, 5'd0, 1, 0);

    repeat (10000) begin
      rop = ($urandom_range(0, 1) != 0) ? 4'(4 + $urandom_range(0, 1)) : 4'($urandom);
      step($urandom_range(0, 3) != 0, rop, $urandom, $urandom_range(0, 1) != 0,
           ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), $urandom_range(0, 2) != 0,
           $urandom_range(0, 63) == 0);
    end
    for (int i = 0; i < 50 && q.size() > 0; i++) step(0, 4'b0000, 32'h0, 0, 5'd0, 1, 0);
    chk("drain_empty", q.size(), 32'd0);

    // saturation and clear priority
    repeat (300) step(1, 4'b0100, $urandom, 1, 5'd2, 1, 0);
    step(0, 4'b0000, 32'h0, 0, 5'd0, 1, 0);
    step(0, 4'b0000, 32'h0, 0, 5'd0, 1, 0);
    chk("cnt_saturated", ovf_cnt, CNT_MAX);
    step(1, 4'b0101, 32'h77, 1, 5'd4, 1, 1);
    step(0, 4'b0000, 32'h0, 0, 5'd0, 1, 0);
    step(0, 4'b0000, 32'h0, 0, 5'd0, 1, 0);
    chk("clr_priority", {ovf_sticky, ovf_cnt}, 32'd0);

    // reset mid-operation with two entries held
    step(1, 4'b0101, 32'h11, 1, 5'd5, 0, 0);
    step(1, 4'b0000, 32'h22, 0, 5'd6, 0, 0);
    step(0, 4'b0000, 32'h0, 0, 5'd0, 0, 0);
    chk("held_valid", wb_valid, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_flush_valid", wb_valid, 32'd0);
    chk("rst_flush_ready", in_ready, 32'd1);
    chk("rst_flush_ovf", {ovf_sticky, ovf_cnt}, 32'd0);
    q.delete();
    m_sticky = 0;
    m_cnt = 0;
    @(negedge clk) rst_n = 1'b1;
    step(1, 4'b0011, 32'h99, 0, 5'd8, 1, 0);
    step(0, 4'b0000, 32'h0, 0, 5'd0, 1, 0);
    step(0, 4'b0000, 32'h0, 0, 5'd0, 1, 0);
    chk("post_rst_empty", q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
